dclk_tx_mlane: RTL and testbench

- Parametrised multi-lane successor to the single-lane dclk serial transmitter.
- Accepts a DATA_W-bit flit via a req/busy handshake and serialises it LSB-first across LANES parallel wires.
- Each lane frame is: start bit, data slice, optional even-parity bit.
- Sits between a router output port and the inter-router link.
- Honours a channel_busy back-pressure signal from the link, synchronised through SYNC_STAGES flops.
- Enforces a programmable idle gap between frames.

---
 rtl/dclk_tx_mlane.sv | 88 ++++++++
 tb/tb_dclk_tx_mlane.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dclk_tx_mlane.sv
// dclk_tx_mlane: multi-lane serial transmitter (start bit, LSB-first data slice, optional even parity)
// with req/busy handshake, synchronised link back-pressure and a programmable inter-frame gap.
module dclk_tx_mlane #(
    parameter int DATA_W      = 24,
    parameter int LANES       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_EN   = 0,
    parameter int IDLE_GAP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              channel_busy,
    output logic              tx_busy,
    output logic              accept,
    output logic              done,
    output logic              tx_active,
    output logic [LANES-1:0]  serial_out
);
    localparam int BPL       = (DATA_W + LANES - 1) / LANES;
    localparam int FRAME_LEN = 1 + BPL + PARITY_EN;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam int PW        = BPL * LANES;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                      state, nxt;
    logic [CW-1:0]               cnt;
    logic [7:0]                  gcnt;
    logic [SYNC_STAGES-1:0]      sync;
    logic [LANES-1:0][BPL-1:0]   sh, lane_in;
    logic [LANES-1:0]            par, lane_par, lsb;
    logic [PW-1:0]               pad;
    logic                        busy_sync, last;

    assign pad       = PW'(parallel_in);
    assign busy_sync = sync[SYNC_STAGES-1];
    assign tx_active = state == SEND;
    assign tx_busy   = tx_active | busy_sync | (state == GAP);
    // gated by reset so no accept is reported while the block is held in reset
    assign accept    = reset & req & ~tx_busy & (state == IDLE);
    assign last      = tx_active && cnt == CW'(FRAME_LEN - 1);
    assign done      = last;

    genvar k, j;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            for (j = 0; j < BPL; j++) begin : g_slot
                assign lane_in[k][j] = pad[j*LANES + k];
            end
            assign lane_par[k] = ^lane_in[k];
            assign lsb[k]      = sh[k][0];
        end
    endgenerate

    always_comb begin
        serial_out = !tx_active ? '0 : cnt == '0 ? '1 : cnt <= CW'(BPL) ? lsb : par;
        nxt = state == IDLE ? (accept ? SEND : IDLE)
            : state == SEND ? (last ? (IDLE_GAP > 0 ? GAP : IDLE) : SEND)
            : (gcnt == 8'(IDLE_GAP - 1) ? IDLE : GAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            sync  <= '0;
            sh    <= '0;
            par   <= '0;
        end else begin
            state <= nxt;
            sync  <= {sync[SYNC_STAGES-2:0], channel_busy};
            gcnt  <= state == GAP ? gcnt + 8'd1 : 8'd0;
            if (accept) begin
                sh  <= lane_in;
                par <= lane_par;
                cnt <= '0;
            end else if (tx_active) begin
                cnt <= cnt + 1'b1;
                // the start-bit cycle leaves the shifters untouched
                if (cnt != '0)
                    for (int i = 0; i < LANES; i++) sh[i] <= sh[i] >> 1;
            end
        end
    end
endmodule

// File: tb/tb_dclk_tx_mlane.sv
// tb_dclk_tx_mlane: randomized and directed bench for dclk_tx_mlane against a queue-based
// frame model (2 lanes, 7-bit flits with padding, parity, 3-cycle gap, 3-stage sync).
module tb_dclk_tx_mlane;
    localparam int DW = 7, LN = 2, SS = 3, PE = 1, IG = 3;
    localparam int BPL = (DW + LN - 1) / LN;
    localparam int FL  = 1 + BPL + PE;

    logic          clk = 0, reset = 0, req = 0, channel_busy = 0;
    logic [DW-1:0] parallel_in = '0;
    logic          tx_busy, accept, done, tx_active;
    logic [LN-1:0] serial_out;
    int            checks = 0, fails = 0;

    always #5 clk = ~clk;

    dclk_tx_mlane #(.DATA_W(DW), .LANES(LN), .SYNC_STAGES(SS), .PARITY_EN(PE), .IDLE_GAP(IG)) dut (
        .clk(clk), .reset(reset), .req(req), .parallel_in(parallel_in),
        .channel_busy(channel_busy), .tx_busy(tx_busy), .accept(accept),
        .done(done), .tx_active(tx_active), .serial_out(serial_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one queue entry per future cycle of frame output, empty queue means idle.
    typedef struct packed {logic [LN-1:0] s; logic act; logic dn;} ent_t;
    ent_t        q[$];
    logic [SS-1:0] hist;
    logic        m_acc;
    ent_t        c_e;
    logic        c_busy, c_acc;

    function automatic logic lane_bit(input logic [DW-1:0] d, input int ln, input int slot);
        int idx = slot * LN + ln;
        if (slot < 0 || idx >= DW) return 1'b0;
        return d[idx];
    endfunction

    task automatic push_frame(input logic [DW-1:0] d);
        ent_t e;
        for (int i = 0; i < FL; i++) begin
            e.act = 1'b1;
            e.dn  = (i == FL - 1);
            for (int l = 0; l < LN; l++) begin
                logic p;
                p = 1'b0;
                for (int s = 0; s < BPL; s++) p ^= lane_bit(d, l, s);
                e.s[l] = i == 0 ? 1'b1 : i <= BPL ? lane_bit(d, l, i - 1) : p;
            end
            q.push_back(e);
        end
        for (int i = 0; i < IG; i++) q.push_back('0);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            hist = '0;
        end else begin
            m_acc = req && q.size() == 0 && !hist[SS-1];
            if (q.size() != 0) void'(q.pop_front());
            if (m_acc) push_frame(parallel_in);
            hist = {hist[SS-2:0], channel_busy};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            c_e = '0; c_busy = 1'b0; c_acc = 1'b0;
        end else begin
            c_e    = q.size() != 0 ? q[0] : '0;
            c_busy = q.size() != 0 || hist[SS-1];
            c_acc  = req && !c_busy;
        end
        chk("serial_out", 32'(serial_out), 32'(c_e.s));
        chk("tx_active", 32'(tx_active), 32'(c_e.act));
        chk("done", 32'(done), 32'(c_e.dn));
        chk("tx_busy", 32'(tx_busy), 32'(c_busy));
        chk("accept", 32'(accept), 32'(c_acc));
    end

    task automatic wait_acc(input int lim, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (accept) return;
            n++;
            if (n >= lim) begin
                checks++; fails++;
                $display("FAIL accept_timeout: got no accept expected one within %0d cycles", lim);
                return;
            end
        end
    endtask

    task automatic send_cap(input logic [DW-1:0] d, output logic [LN*FL-1:0] seq);
        int n;
        @(posedge clk); #1 req = 1; parallel_in = d;
        wait_acc(100, n);
        @(posedge clk); #1 req = 0; parallel_in = DW'($urandom);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            seq[i*LN +: LN] = serial_out;
        end
        repeat (IG + 2) @(posedge clk);
    endtask

    initial begin
        logic [LN*FL-1:0] seq;
        int n, na;
        int t[8];
        repeat (2) @(posedge clk);
        #1 req = 1;
        @(negedge clk);
        chk("rst_accept", 32'(accept), 0);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_serial", 32'(serial_out), 0);
        @(posedge clk); #1 reset = 1; req = 0;

        send_cap(7'h7F, seq);
        chk("frame_7f", 32'(seq), 32'(12'b10_01_11_11_11_11));
        send_cap(7'h25, seq);
        chk("frame_25", 32'(seq), 32'(12'b10_00_10_01_01_11));

        @(posedge clk); #1 channel_busy = 1;
        repeat (SS + 1) @(posedge clk);
        #1 req = 1; parallel_in = 7'h5A;
        repeat (4) begin
            @(negedge clk);
            chk("cb_accept_blocked", 32'(accept), 0);
            chk("cb_tx_busy", 32'(tx_busy), 1);
        end
        @(posedge clk); #1 channel_busy = 0;
        wait_acc(20, n);
        chk("cb_release_latency", 32'(n), SS);
        @(posedge clk); #1 req = 0;
        @(posedge clk); #1 channel_busy = 1;
        repeat (FL) @(posedge clk);
        #1 channel_busy = 0;
        repeat (SS + IG + 2) @(posedge clk);

        #1 req = 1;
        na = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (accept && na < 8) begin t[na] = c; na++; end
            @(posedge clk); #1 parallel_in = DW'($urandom);
        end
        req = 0;
        chk("gap_accept_count", 32'(na >= 4), 1);
        for (int i = 1; i < 4; i++) chk("gap_spacing", 32'(t[i] - t[i-1]), FL + IG + 1);
        repeat (FL + IG + 2) @(posedge clk);

        #1 req = 1; parallel_in = 7'h33;
        wait_acc(20, n);
        @(posedge clk); #1 req = 0;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        #1;
        chk("rst_mid_serial", 32'(serial_out), 0);
        chk("rst_mid_active", 32'(tx_active), 0);
        chk("rst_mid_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1; req = 1;
        wait_acc(10, n);
        chk("rst_reaccept", 32'(n <= SS + 1), 1);
        @(posedge clk); #1 req = 0;
        repeat (FL + IG + 2) @(posedge clk);

        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            req = $urandom_range(0, 2) != 0;
            parallel_in = DW'($urandom);
            if ($urandom_range(0, 15) == 0) channel_busy = ~channel_busy;
        end
        req = 0; channel_busy = 0;
        repeat (FL + IG + SS + 4) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
